// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// A single memory port handles refills and a second handles write-through; stall is combinational.
module dcache_responder #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_raddr_i,
  input  logic        dcache_rreq_i,
  input  logic [31:0] dcache_waddr_i,
  input  logic [31:0] dcache_wdata_i,
  input  logic [3:0]  dcache_wsel_i,
  input  logic        dcache_wreq_i,
  output logic [31:0] dcache_data_o,
  output logic        dcache_stall_o,
  output logic [31:0] mem_raddr_o,
  output logic        mem_rreq_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wsel_o,
  output logic        mem_wreq_o,
  input  logic        mem_wready_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 32 - INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic               wr_done_q;

  logic [INDEX_W-1:0] r_idx, w_idx, f_idx;
  logic [TAG_W-1:0]   r_tag, w_tag, f_tag;
  logic               r_hit, w_hit, wreq_eff;
  logic               refill_we, wr_hit_we;
  logic [31:0]        merged;

  assign r_idx = dcache_raddr_i[INDEX_W-1:0];
  assign r_tag = dcache_raddr_i[31:INDEX_W];
  assign w_idx = dcache_waddr_i[INDEX_W-1:0];
  assign w_tag = dcache_waddr_i[31:INDEX_W];
  // Refill target comes from the held refill address, not the live request.
  assign f_idx = mem_raddr_o[INDEX_W-1:0];
  assign f_tag = mem_raddr_o[31:INDEX_W];

  // Lookup, byte merge, array write enables and stall.
  always_comb begin
    r_hit          = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    w_hit          = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    wreq_eff       = dcache_wreq_i && !wr_done_q;
    refill_we      = (state_q == REFILL) && mem_rvalid_i;
    wr_hit_we      = (state_q == IDLE) && wreq_eff && w_hit;
    merged         = data_q[w_idx];
    for (int k = 0; k < 4; k++) begin
      if (dcache_wsel_i[k]) merged[8*k +: 8] = dcache_wdata_i[8*k +: 8];
    end
    dcache_stall_o = 1'b0;
    case (state_q)
      IDLE:    dcache_stall_o = wreq_eff || (dcache_rreq_i && !r_hit);
      REFILL:  dcache_stall_o = 1'b1;
      WRITE:   dcache_stall_o = !mem_wready_i || dcache_rreq_i;
      default: dcache_stall_o = 1'b1;
    endcase
  end

  // Tag/data storage carries no reset; validity alone qualifies a line.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_q[f_idx]  <= f_tag;
      data_q[f_idx] <= mem_rdata_i;
    end else if (wr_hit_we) begin
      data_q[w_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      wr_done_q     <= 1'b0;
      dcache_data_o <= '0;
      mem_raddr_o   <= '0;
      mem_rreq_o    <= 1'b0;
      mem_waddr_o   <= '0;
      mem_wdata_o   <= '0;
      mem_wsel_o    <= '0;
      mem_wreq_o    <= 1'b0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
    end else begin
      // wr_done masks a write already served while a paired read is pending.
      if (!dcache_stall_o) begin
        wr_done_q <= 1'b0;
      end else if (state_q == WRITE && mem_wready_i) begin
        wr_done_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (wreq_eff) begin
            mem_waddr_o <= dcache_waddr_i;
            mem_wdata_o <= dcache_wdata_i;
            mem_wsel_o  <= dcache_wsel_i;
            mem_wreq_o  <= 1'b1;
            state_q     <= WRITE;
          end else if (dcache_rreq_i) begin
            if (r_hit) begin
              dcache_data_o <= data_q[r_idx];
              hit_cnt_o     <= hit_cnt_o + 32'd1;
            end else begin
              mem_raddr_o <= dcache_raddr_i;
              mem_rreq_o  <= 1'b1;
              miss_cnt_o  <= miss_cnt_o + 32'd1;
              state_q     <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_rvalid_i) begin
            valid_q[f_idx] <= 1'b1;
            mem_rreq_o     <= 1'b0;
            state_q        <= IDLE;
          end
        end
        WRITE: begin
          if (mem_wready_i) begin
            mem_wreq_o <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter INDEX_W, default 4, index width; the cache holds 2**INDEX_W lines of one 32-bit word each.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 dcache_raddr_i  input  32  read word address: index = [INDEX_W-1:0], tag = [31:INDEX_W].
REQ-005 dcache_rreq_i  input  1  read request.
REQ-006 dcache_waddr_i / dcache_wdata_i / dcache_wsel_i  input  32/32/4  write word address, write data and byte enables (bit k covers byte k).
REQ-007 dcache_wreq_i  input  1  write request.
REQ-008 dcache_data_o  output  32  read data, registered.
REQ-009 dcache_stall_o  output  1  combinational; while high the requester holds all request inputs unchanged.
REQ-010 mem_raddr_o / mem_rreq_o  output  32/1  refill address and refill request, registered.
REQ-011 mem_rdata_i / mem_rvalid_i  input  32/1  refill data, and its one-cycle valid strobe.
REQ-012 mem_waddr_o / mem_wdata_o / mem_wsel_o / mem_wreq_o  output  32/32/4/1  write-through port, registered.
REQ-013 mem_wready_i  input  1  write accepted by memory in this cycle.
REQ-014 hit_cnt_o / miss_cnt_o  output  32/32  read hit and read miss counters.

Function
REQ-015 Organisation: direct-mapped cache; each line holds valid, tag and data. Writes are write-through with no allocate on a miss.
REQ-016 FSM states: IDLE, REFILL, WRITE.
REQ-017 IDLE, read hit (wreq low):
- dcache_data_o = line data on the next edge.
- stall_o low.
- hit_cnt_o +1.
- Back-to-back hits give one result per cycle.
REQ-018 IDLE, read miss (wreq low):
- stall_o high.
- mem_raddr_o = raddr and mem_rreq_o = 1 on the next edge; enter REFILL.
- miss_cnt_o +1, counted once per miss.
REQ-019 REFILL: stall_o high; mem_rreq_o held high until the mem_rvalid_i cycle.
- In that cycle, write valid=1, tag and mem_rdata_i into the line.
- Drop mem_rreq_o; return to IDLE.
- The held request then re-looks up and hits (counted as a hit); total miss latency = memory latency + 3 cycles.
REQ-020 IDLE with wreq:
- On a tag hit, merge the enabled bytes into the line on the next edge. On a miss the array is unchanged.
- Load mem_waddr_o/mem_wdata_o/mem_wsel_o and set mem_wreq_o = 1; enter WRITE; stall_o high.
- wsel = 0000 still issues a memory write with mem_wsel_o = 0000.
REQ-021 WRITE:
- stall_o = ~mem_wready_i, except it stays high when dcache_rreq_i is also pending.
- On mem_wready_i: drop mem_wreq_o and return to IDLE.
REQ-022 Simultaneous rreq and wreq: the write is served first.
- After the write completes, an internal wr_done flag suppresses the still-held wreq.
- The read then proceeds per REQ-017/018 and sees the written data.
- wr_done clears when stall_o falls.
REQ-023 dcache_data_o holds its last value when no read completes.
REQ-024 Counters wrap modulo 2**32.
REQ-025 Lines with equal index and different tags evict each other; there is no replacement state.

Reset
REQ-026 While rst is low, independent of clk:
- state = IDLE; all valid bits = 0; wr_done = 0.
- All registered outputs = 0.
- Array data and tags need not be cleared.
REQ-027 If reset asserts mid-REFILL or mid-WRITE, the transaction is abandoned and mem_*req_o drop immediately; no line is marked valid.

Verification
REQ-028 Reset, then read address 3 with memory returning 0x1234 after 2 cycles:
- 1 miss; mem_raddr_o = 3.
- dcache_data_o = 0x1234.
- miss_cnt = 1, hit_cnt = 1.
REQ-029 Write addresses 0..15 with data[i] and wsel 1111, memory always ready; then read 16 random addresses 0..15:
- After the first touch of each index, every read returns data[i].
- dcache_data_o is valid one cycle after each hit.
REQ-030 Line 5 valid with 0xAABBCCDD; write 0x11223344 wsel 0101 to address 5 → subsequent read returns 0xAA22CC44; mem_wsel_o = 0101.
REQ-031 Read address 2 (fill), then address 18 (same index, new tag) → second read misses; a later read of address 2 misses again.
REQ-032 Simultaneous wreq (addr 7, 0x55) and rreq (addr 7), memory delaying wready 3 cycles:
- Exactly one memory write.
- The read returns 0x55.
- stall_o falls only after the read completes.
REQ-033 Assert rst during REFILL → mem_rreq_o = 0 immediately; after release, the same address misses again.
